fifo_ctrl: RTL and testbench

Pointer and flag controller for the UART TX/RX FIFOs. It accepts push/pop requests from the UART datapath and produces the write/read strobes and 4-bit pointers that drive the 16-entry FIFO storage array. It also provides full/empty/count status and a read-data-valid strobe aligned with the storage array's registered read output. One instance sits beside each FIFO storage array, on the control side.

---
 rtl/fifo_pkg.sv | 17 +
 rtl/fifo_ptr.sv | 25 ++
 rtl/fifo_ctrl.sv | 103 ++++++++++
 tb/tb_fifo_ctrl.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
`default_nettype none
// =============================================================================
// Module      : fifo_pkg
// Description : Shared widths and pointer/count types for the FIFO controller.
// Revision    : 1.0
// =============================================================================
package fifo_pkg;

    localparam int FIFO_ADDR_WIDTH = 4;
    localparam int FIFO_DEPTH      = 16;

    // Bit FIFO_ADDR_WIDTH is the wrap bit; lower bits address the array.
    typedef logic [FIFO_ADDR_WIDTH:0] fifo_ptr_t;
    typedef logic [FIFO_ADDR_WIDTH:0] fifo_cnt_t;

endpackage
`default_nettype wire

// File: rtl/fifo_ptr.sv
`default_nettype none
// =============================================================================
// Module      : fifo_ptr
// Description : Wrap-bit pointer register, increments modulo 2*DEPTH when inc.
// Revision    : 1.0
// =============================================================================
module fifo_ptr
    import fifo_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      inc,
    output fifo_ptr_t ptr
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= ptr + fifo_ptr_t'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/fifo_ctrl.sv
`default_nettype none
// =============================================================================
// Module      : fifo_ctrl
// Description : Pointer, strobe and status controller for a 16-entry FIFO.
//               Optional watermark flags: define FIFO_CTRL_WATERMARK_EN.
// Revision    : 1.0
// =============================================================================
module fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH,
    parameter int DEPTH      = FIFO_DEPTH
`ifdef FIFO_CTRL_WATERMARK_EN
    ,
    parameter int AF_LEVEL   = 12,
    parameter int AE_LEVEL   = 4
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_req,
    input  logic                  rd_req,
    output logic                  can_write,
    output logic                  can_read,
    output logic [ADDR_WIDTH-1:0] wr_ptr,
    output logic [ADDR_WIDTH-1:0] rd_ptr,
    output logic                  rd_valid,
    output logic                  full,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
`ifdef FIFO_CTRL_WATERMARK_EN
    ,
    output logic                  almost_full,
    output logic                  almost_empty
`endif
);

    fifo_ptr_t r_wr_q;
    fifo_ptr_t r_rd_q;
    fifo_cnt_t w_count;

    fifo_ptr u_wr_ptr (
        .clk (clk),
        .rst (rst),
        .inc (can_write),
        .ptr (r_wr_q)
    );

    fifo_ptr u_rd_ptr (
        .clk (clk),
        .rst (rst),
        .inc (can_read),
        .ptr (r_rd_q)
    );

    assign wr_ptr  = r_wr_q[ADDR_WIDTH-1:0];
    assign rd_ptr  = r_rd_q[ADDR_WIDTH-1:0];
    assign w_count = r_wr_q - r_rd_q;
    assign count   = w_count;
    assign empty   = (r_wr_q == r_rd_q);
    // Equal addresses with opposite wrap bits is exactly a difference of DEPTH.
    assign full    = (w_count == fifo_cnt_t'(DEPTH));

    // A pop frees the slot a simultaneous push needs when full; no fall-through when empty.
    assign can_read  = rd_req & ~empty;
    assign can_write = wr_req & (~full | can_read);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_valid  <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            rd_valid <= can_read;
            if (wr_req && !can_write) begin
                overflow <= 1'b1;
            end
            if (rd_req && empty) begin
                underflow <= 1'b1;
            end
        end
    end

`ifdef FIFO_CTRL_WATERMARK_EN
    fifo_cnt_t w_count_next;

    assign w_count_next = w_count + fifo_cnt_t'(can_write) - fifo_cnt_t'(can_read);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
        end else begin
            almost_full  <= (w_count_next >= fifo_cnt_t'(AF_LEVEL));
            almost_empty <= (w_count_next <= fifo_cnt_t'(AE_LEVEL));
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_ctrl.sv
`default_nettype none
// =============================================================================
// Module      : tb_fifo_ctrl
// Description : Self-checking bench for fifo_ctrl against an occupancy model.
// Revision    : 1.0
// =============================================================================
module tb_fifo_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       wr_req = 1'b0;
    logic       rd_req = 1'b0;
    logic       can_write, can_read, rd_valid, full, empty, overflow, underflow;
    logic [3:0] wr_ptr, rd_ptr;
    logic [4:0] count;
`ifdef FIFO_CTRL_WATERMARK_EN
    logic       almost_full, almost_empty;
`endif

    int tests = 0;
    int fails = 0;

    // Model: total accepted pushes/pops since reset; everything else derives from them.
    int wr_total = 0;
    int rd_total = 0;
    bit m_cw, m_cr, m_rv, m_ovf, m_unf;

    always #5 clk = ~clk;

    fifo_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .wr_req       (wr_req),
        .rd_req       (rd_req),
        .can_write    (can_write),
        .can_read     (can_read),
        .wr_ptr       (wr_ptr),
        .rd_ptr       (rd_ptr),
        .rd_valid     (rd_valid),
        .full         (full),
        .empty        (empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
`ifdef FIFO_CTRL_WATERMARK_EN
        ,
        .almost_full  (almost_full),
        .almost_empty (almost_empty)
`endif
    );

    function automatic int m_count();
        return wr_total - rd_total;
    endfunction

    task automatic model_reset();
        wr_total = 0;
        rd_total = 0;
        m_cw = 0; m_cr = 0; m_rv = 0; m_ovf = 0; m_unf = 0;
    endtask

    task automatic apply(input bit w, input bit r);
        wr_req = w;
        rd_req = r;
        #1;
        m_cr = r && (m_count() > 0);
        m_cw = w && ((m_count() < 16) || m_cr);
    endtask

    task automatic clock_in();
        @(posedge clk);
        #1;
        if (wr_req && !m_cw) m_ovf = 1;
        if (rd_req && m_count() == 0) m_unf = 1;
        if (m_cw) wr_total++;
        if (m_cr) rd_total++;
        m_rv = m_cr;
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #1;
        tests++; if (count !== 5'd0 || wr_ptr !== 4'd0 || rd_ptr !== 4'd0) begin
            fails++; $display("FAIL reset_ptrs: count=%0d wr=%0d rd=%0d required 0/0/0", count, wr_ptr, rd_ptr);
        end
        tests++; if (empty !== 1'b1 || full !== 1'b0) begin
            fails++; $display("FAIL reset_flags: empty=%b full=%b required 1/0", empty, full);
        end
        tests++; if (rd_valid !== 1'b0 || overflow !== 1'b0 || underflow !== 1'b0) begin
            fails++; $display("FAIL reset_regs: rv=%b ovf=%b unf=%b required 0/0/0", rd_valid, overflow, underflow);
        end
`ifdef FIFO_CTRL_WATERMARK_EN
        tests++; if (almost_empty !== 1'b1 || almost_full !== 1'b0) begin
            fails++; $display("FAIL reset_wm: ae=%b af=%b required 1/0", almost_empty, almost_full);
        end
`endif
        #1 rst = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    task automatic test_fill();
        for (int i = 0; i < 16; i++) begin
            apply(1, 0);
            tests++; if (wr_ptr !== 4'(i) || can_write !== 1'b1) begin
                fails++; $display("FAIL fill_step %0d: wr_ptr=%0d cw=%b required %0d/1", i, wr_ptr, can_write, i);
            end
            clock_in();
        end
        apply(0, 0);
        tests++; if (full !== 1'b1 || empty !== 1'b0 || count !== 5'd16 || wr_ptr !== 4'd0) begin
            fails++; $display("FAIL fill_end: full=%b empty=%b count=%0d wr=%0d required 1/0/16/0", full, empty, count, wr_ptr);
        end
    endtask

    task automatic test_overflow();
        apply(1, 0);
        tests++; if (can_write !== 1'b0) begin
            fails++; $display("FAIL ovf_cw: got %b required 0", can_write);
        end
        clock_in();
        apply(0, 0);
        tests++; if (overflow !== 1'b1 || count !== 5'd16 || wr_ptr !== 4'd0 || rd_ptr !== 4'd0) begin
            fails++; $display("FAIL ovf_state: ovf=%b count=%0d wr=%0d rd=%0d required 1/16/0/0", overflow, count, wr_ptr, rd_ptr);
        end
    endtask

    task automatic test_drain();
        for (int i = 0; i < 16; i++) begin
            apply(0, 1);
            tests++; if (rd_ptr !== 4'(i) || can_read !== 1'b1) begin
                fails++; $display("FAIL drain_step %0d: rd_ptr=%0d cr=%b required %0d/1", i, rd_ptr, can_read, i);
            end
            clock_in();
            tests++; if (rd_valid !== 1'b1) begin
                fails++; $display("FAIL drain_rv %0d: got %b required 1", i, rd_valid);
            end
        end
        apply(0, 0);
        tests++; if (empty !== 1'b1 || count !== 5'd0 || rd_ptr !== 4'd0) begin
            fails++; $display("FAIL drain_end: empty=%b count=%0d rd=%0d required 1/0/0", empty, count, rd_ptr);
        end
        clock_in();
        tests++; if (rd_valid !== 1'b0) begin
            fails++; $display("FAIL drain_rv_idle: got %b required 0", rd_valid);
        end
    endtask

    task automatic test_empty_push_pop();
        apply(1, 1);
        tests++; if (can_read !== 1'b0 || can_write !== 1'b1) begin
            fails++; $display("FAIL empty_pp_strobes: cr=%b cw=%b required 0/1", can_read, can_write);
        end
        clock_in();
        apply(0, 0);
        tests++; if (count !== 5'd1 || underflow !== 1'b1 || rd_valid !== 1'b0) begin
            fails++; $display("FAIL empty_pp_state: count=%0d unf=%b rv=%b required 1/1/0", count, underflow, rd_valid);
        end
    endtask

    task automatic test_full_push_pop();
        while (m_count() < 16) begin
            apply(1, 0);
            clock_in();
        end
        for (int i = 0; i < 20; i++) begin
            apply(1, 1);
            tests++; if (can_read !== 1'b1 || can_write !== 1'b1 || wr_ptr !== rd_ptr) begin
                fails++; $display("FAIL full_pp_cyc %0d: cr=%b cw=%b wr=%0d rd=%0d required 1/1/equal", i, can_read, can_write, wr_ptr, rd_ptr);
            end
            clock_in();
            tests++; if (count !== 5'd16 || full !== 1'b1 || wr_ptr !== 4'(wr_total % 16)) begin
                fails++; $display("FAIL full_pp_state %0d: count=%0d full=%b wr=%0d required 16/1/%0d", i, count, full, wr_ptr, wr_total % 16);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            int bias;
            bias = ((i / 100) % 2 == 0) ? 75 : 25;
            apply($urandom_range(0, 99) < bias, $urandom_range(0, 99) >= bias);
            tests++; if (can_write !== m_cw || can_read !== m_cr) begin
                fails++; $display("FAIL rand_strobes %0d: cw=%b cr=%b required %b/%b", i, can_write, can_read, m_cw, m_cr);
            end
            tests++; if (count !== 5'(m_count()) || full !== (m_count() == 16) || empty !== (m_count() == 0)) begin
                fails++; $display("FAIL rand_status %0d: count=%0d full=%b empty=%b required %0d", i, count, full, empty, m_count());
            end
            tests++; if (wr_ptr !== 4'(wr_total % 16) || rd_ptr !== 4'(rd_total % 16)) begin
                fails++; $display("FAIL rand_ptrs %0d: wr=%0d rd=%0d required %0d/%0d", i, wr_ptr, rd_ptr, wr_total % 16, rd_total % 16);
            end
            clock_in();
            tests++; if (rd_valid !== m_rv || overflow !== m_ovf || underflow !== m_unf) begin
                fails++; $display("FAIL rand_regs %0d: rv=%b ovf=%b unf=%b required %b/%b/%b", i, rd_valid, overflow, underflow, m_rv, m_ovf, m_unf);
            end
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 5; i++) begin
            apply(1, 0);
            clock_in();
        end
        apply(1, 0);
        #2 rst = 1'b1;
        #1;
        tests++; if (count !== 5'd0 || wr_ptr !== 4'd0 || rd_ptr !== 4'd0 || empty !== 1'b1) begin
            fails++; $display("FAIL async_rst: count=%0d wr=%0d rd=%0d empty=%b required 0/0/0/1", count, wr_ptr, rd_ptr, empty);
        end
        tests++; if (rd_valid !== 1'b0 || overflow !== 1'b0 || underflow !== 1'b0) begin
            fails++; $display("FAIL async_rst_regs: rv=%b ovf=%b unf=%b required 0/0/0", rd_valid, overflow, underflow);
        end
        wr_req = 1'b0;
        #2 rst = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        apply(1, 0);
        tests++; if (wr_ptr !== 4'd0 || can_write !== 1'b1) begin
            fails++; $display("FAIL async_next_push: wr=%0d cw=%b required 0/1", wr_ptr, can_write);
        end
        clock_in();
        apply(0, 0);
        tests++; if (wr_ptr !== 4'd1 || count !== 5'd1) begin
            fails++; $display("FAIL async_after_push: wr=%0d count=%0d required 1/1", wr_ptr, count);
        end
    endtask

`ifdef FIFO_CTRL_WATERMARK_EN
    task automatic test_watermark();
        while (m_count() < 12) begin
            apply(1, 0);
            clock_in();
            tests++; if (almost_full !== (m_count() >= 12) || almost_empty !== (m_count() <= 4)) begin
                fails++; $display("FAIL wm_up count %0d: af=%b ae=%b", m_count(), almost_full, almost_empty);
            end
        end
        while (m_count() > 4) begin
            apply(0, 1);
            clock_in();
            tests++; if (almost_full !== (m_count() >= 12) || almost_empty !== (m_count() <= 4)) begin
                fails++; $display("FAIL wm_down count %0d: af=%b ae=%b", m_count(), almost_full, almost_empty);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_fill();
        test_overflow();
        test_drain();
        test_empty_push_pop();
        test_full_push_pop();
        test_random();
        test_async_reset();
`ifdef FIFO_CTRL_WATERMARK_EN
        test_watermark();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
